// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port between NUM_REQ producers.
// Data passes through combinationally; grant, beat count, pointer and write count are registered.
module fifo_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                                       wclk,
    input  logic                                       wrst,
    input  logic [NUM_REQ-1:0]                         req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_data,
    input  logic [NUM_REQ-1:0]                         req_last,
    output logic [NUM_REQ-1:0]                         req_ready,
    input  logic                                       wFull,
    output logic                                       winc,
    output logic [DATA_WIDTH-1:0]                      wData,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] grant_id,
    output logic                                       busy,
    output logic [15:0]                                write_count
);

    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [IDW-1:0] ptr_q,   ptr_d;
    logic [7:0]     beat_q,  beat_d;
    logic [15:0]    wcnt_q,  wcnt_d;

    logic [IDW-1:0] pick_s;
    logic           found_s;

    // Round-robin search starting just above the last granted requester.
    always_comb begin
        int idx;
        logic [IDW-1:0] cand;
        pick_s  = '0;
        found_s = 1'b0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(ptr_q) + k) % NUM_REQ;
            cand = IDW'(idx);
            if (!found_s && req_valid[cand]) begin
                found_s = 1'b1;
                pick_s  = cand;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state logic and pass-through write path.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        wcnt_d    = wcnt_q;
        req_ready = '0;
        winc      = 1'b0;
        wData     = '0;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_GRANT;
                    grant_d = pick_s;
                    ptr_d   = pick_s;
                    beat_d  = 8'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GRANT: begin
                req_ready[grant_q] = !wFull;
                // A requester that goes idle gives up the port, even during a stall.
                if (!req_valid[grant_q]) begin
                    state_d = ST_IDLE;
                end else if (!wFull) begin
                    winc   = 1'b1;
                    wData  = req_data[int'(grant_q) * DATA_WIDTH +: DATA_WIDTH];
                    beat_d = beat_q + 8'd1;
                    wcnt_d = wcnt_q + 16'd1;
                    if (req_last[grant_q] || (beat_q + 8'd1 == 8'(MAX_BURST))) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_GRANT;
                    end
                end else begin
                    state_d = ST_GRANT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Reset aborts the current beat in the same cycle.
        if (wrst) begin
            req_ready = '0;
            winc      = 1'b0;
            wData     = '0;
        end else begin
            winc      = winc;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IDW'(NUM_REQ - 1);
            beat_q  <= 8'd0;
            wcnt_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign grant_id    = grant_q;
    assign busy        = (state_q == ST_GRANT);
    assign write_count = wcnt_q;

endmodule
